// File: rtl/axi_rd_arbiter.sv
// -----------------------------------------------------------------------------
// axi_rd_arbiter
//
// Shares a single burst read channel between the instruction cache (i_*) and
// the data cache (d_*). Only one burst is in flight at a time. On a tie in
// IDLE the side that was not granted last time wins.
//
// Ports
//   clk, rst                        clock, synchronous active-high reset
//   i_ar* / i_arready               instruction-side address channel
//   i_r*  / i_rready                instruction-side response channel
//   d_ar* / d_arready               data-side address channel
//   d_r*  / d_rready                data-side response channel
//   araddr/arlen/arsize/arid/arvalid, arready   shared request to memory
//   rdata/rlast/rvalid, rready      shared response from memory
//   busy                            high whenever the FSM is not in IDLE
//   burst_err                       one-cycle pulse when the number of beats
//                                   seen at rlast differs from arlen+1
// -----------------------------------------------------------------------------
module axi_rd_arbiter #(
  parameter int          ID_WIDTH = 4,
  parameter int unsigned I_ID     = 0,
  parameter int unsigned D_ID     = 1
) (
  input  logic                clk,
  input  logic                rst,

  input  logic [31:0]         i_araddr,
  input  logic [3:0]          i_arlen,
  input  logic [2:0]          i_arsize,
  input  logic                i_arvalid,
  output logic                i_arready,
  output logic [31:0]         i_rdata,
  output logic                i_rlast,
  output logic                i_rvalid,
  input  logic                i_rready,

  input  logic [31:0]         d_araddr,
  input  logic [3:0]          d_arlen,
  input  logic [2:0]          d_arsize,
  input  logic                d_arvalid,
  output logic                d_arready,
  output logic [31:0]         d_rdata,
  output logic                d_rlast,
  output logic                d_rvalid,
  input  logic                d_rready,

  output logic [31:0]         araddr,
  output logic [3:0]          arlen,
  output logic [2:0]          arsize,
  output logic [ID_WIDTH-1:0] arid,
  output logic                arvalid,
  input  logic                arready,
  input  logic [31:0]         rdata,
  input  logic                rlast,
  input  logic                rvalid,
  output logic                rready,

  output logic                busy,
  output logic                burst_err
);

  typedef enum logic [2:0] {IDLE, I_AR, I_R, D_AR, D_R} state_t;

  state_t     r_state;
  state_t     w_next;
  logic       r_last_d;   // 1: data side was granted last, 0: instruction side
  logic [3:0] r_cnt;      // beats accepted in the current burst (wraps mod 16)
  logic [3:0] r_len;      // arlen captured at the address handshake
  logic       w_beat;     // a response beat is accepted this cycle

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    w_next    = r_state;
    w_beat    = 1'b0;
    araddr    = '0;
    arlen     = '0;
    arsize    = '0;
    arid      = '0;
    arvalid   = 1'b0;
    rready    = 1'b0;
    i_arready = 1'b0;
    i_rdata   = '0;
    i_rlast   = 1'b0;
    i_rvalid  = 1'b0;
    d_arready = 1'b0;
    d_rdata   = '0;
    d_rlast   = 1'b0;
    d_rvalid  = 1'b0;

    unique case (r_state)
      IDLE: begin
        // I wins when it is alone, or on a tie when D was granted last.
        if (i_arvalid && (!d_arvalid || r_last_d)) w_next = I_AR;
        else if (d_arvalid)                        w_next = D_AR;
      end
      I_AR: begin
        araddr    = i_araddr;
        arlen     = i_arlen;
        arsize    = i_arsize;
        arid      = ID_WIDTH'(I_ID);
        arvalid   = i_arvalid;
        i_arready = arready;
        if (!i_arvalid)   w_next = IDLE;   // requester withdrew
        else if (arready) w_next = I_R;
      end
      I_R: begin
        arid     = ID_WIDTH'(I_ID);
        i_rdata  = rdata;
        i_rlast  = rlast;
        i_rvalid = rvalid;
        rready   = i_rready;
        w_beat   = rvalid && i_rready;
        if (w_beat && rlast) w_next = IDLE;
      end
      D_AR: begin
        araddr    = d_araddr;
        arlen     = d_arlen;
        arsize    = d_arsize;
        arid      = ID_WIDTH'(D_ID);
        arvalid   = d_arvalid;
        d_arready = arready;
        if (!d_arvalid)   w_next = IDLE;
        else if (arready) w_next = D_R;
      end
      D_R: begin
        arid     = ID_WIDTH'(D_ID);
        d_rdata  = rdata;
        d_rlast  = rlast;
        d_rvalid = rvalid;
        rready   = d_rready;
        w_beat   = rvalid && d_rready;
        if (w_beat && rlast) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign busy = (r_state != IDLE);

  // r_cnt counts beats before this one, so the total including the last beat
  // equals r_len+1 exactly when r_cnt == r_len (mod 16, which also covers
  // arlen=15 / 16 beats).
  assign burst_err = w_beat && rlast && (r_cnt != r_len);

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_last_d <= 1'b0;
      r_cnt    <= '0;
      r_len    <= '0;
    end else begin
      r_state <= w_next;

      if (r_state == IDLE && w_next == I_AR) r_last_d <= 1'b0;
      if (r_state == IDLE && w_next == D_AR) r_last_d <= 1'b1;

      if (arvalid && arready) begin
        r_len <= arlen;
        r_cnt <= '0;
      end else if (w_beat) begin
        r_cnt <= r_cnt + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// -----------------------------------------------------------------------------
// tb_axi_rd_arbiter
//
// Directed bench for axi_rd_arbiter. Inputs are changed 1 ns after a rising
// edge and outputs are checked 1 ns after that, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_axi_rd_arbiter;

  logic        clk;
  logic        rst;
  logic [31:0] i_araddr, d_araddr;
  logic [3:0]  i_arlen, d_arlen;
  logic [2:0]  i_arsize, d_arsize;
  logic        i_arvalid, d_arvalid;
  logic        i_arready, d_arready;
  logic [31:0] i_rdata, d_rdata;
  logic        i_rlast, d_rlast;
  logic        i_rvalid, d_rvalid;
  logic        i_rready, d_rready;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [3:0]  arid;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic        busy;
  logic        burst_err;

  int n_checks = 0;
  int n_errors = 0;

  axi_rd_arbiter #(.ID_WIDTH(4), .I_ID(0), .D_ID(1)) dut (
    .clk(clk), .rst(rst),
    .i_araddr(i_araddr), .i_arlen(i_arlen), .i_arsize(i_arsize),
    .i_arvalid(i_arvalid), .i_arready(i_arready),
    .i_rdata(i_rdata), .i_rlast(i_rlast), .i_rvalid(i_rvalid), .i_rready(i_rready),
    .d_araddr(d_araddr), .d_arlen(d_arlen), .d_arsize(d_arsize),
    .d_arvalid(d_arvalid), .d_arready(d_arready),
    .d_rdata(d_rdata), .d_rlast(d_rlast), .d_rvalid(d_rvalid), .d_rready(d_rready),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arid(arid),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .busy(busy), .burst_err(burst_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    i_araddr = '0; i_arlen = '0; i_arsize = '0; i_arvalid = 1'b0; i_rready = 1'b0;
    d_araddr = '0; d_arlen = '0; d_arsize = '0; d_arvalid = 1'b0; d_rready = 1'b0;
    arready = 1'b0; rdata = '0; rlast = 1'b0; rvalid = 1'b0;

    // ---------------- reset state ----------------
    tick(); tick();
    rst = 1'b0;
    #1;
    check("rst_arvalid",   32'(arvalid),   0);
    check("rst_rready",    32'(rready),    0);
    check("rst_i_arready", 32'(i_arready), 0);
    check("rst_d_arready", 32'(d_arready), 0);
    check("rst_i_rvalid",  32'(i_rvalid),  0);
    check("rst_d_rvalid",  32'(d_rvalid),  0);
    check("rst_burst_err", 32'(burst_err), 0);
    check("rst_busy",      32'(busy),      0);
    check("rst_arid",      32'(arid),      0);

    // ---------------- single I burst, 8 beats ----------------
    i_araddr = 32'h1FC0_0000; i_arlen = 4'd7; i_arsize = 3'd2; i_arvalid = 1'b1;
    arready = 1'b1;
    #1;
    check("t1_idle_arvalid", 32'(arvalid), 0);
    check("t1_idle_busy",    32'(busy),    0);
    tick();  // I_AR
    check("t1_ar_arvalid",   32'(arvalid),   1);
    check("t1_ar_arid",      32'(arid),      0);
    check("t1_ar_araddr",    araddr,         32'h1FC0_0000);
    check("t1_ar_arlen",     32'(arlen),     7);
    check("t1_ar_arsize",    32'(arsize),    2);
    check("t1_ar_i_arready", 32'(i_arready), 1);
    check("t1_ar_d_arready", 32'(d_arready), 0);
    check("t1_ar_busy",      32'(busy),      1);
    tick();  // I_R
    i_arvalid = 1'b0; arready = 1'b0; i_rready = 1'b1;
    for (int b = 0; b < 8; b++) begin
      rvalid = 1'b1; rdata = 32'hA000_0000 + 32'(b); rlast = (b == 7);
      #1;
      check("t1_i_rvalid",  32'(i_rvalid),  1);
      check("t1_i_rdata",   i_rdata,        32'hA000_0000 + 32'(b));
      check("t1_i_rlast",   32'(i_rlast),   (b == 7) ? 1 : 0);
      check("t1_rready",    32'(rready),    1);
      check("t1_d_rvalid",  32'(d_rvalid),  0);
      check("t1_burst_err", 32'(burst_err), 0);
      check("t1_busy",      32'(busy),      1);
      tick();
    end
    rvalid = 1'b0; rlast = 1'b0;
    #1;
    check("t1_end_busy",   32'(busy),   0);
    check("t1_end_rready", 32'(rready), 0);

    // ---------------- tie out of reset: D first, then I ----------------
    rst = 1'b1;
    tick();
    rst = 1'b0;
    i_araddr = 32'h0000_1000; i_arlen = 4'd3; i_arvalid = 1'b1;
    d_araddr = 32'h8000_0000; d_arlen = 4'd1; d_arvalid = 1'b1;
    arready = 1'b1;
    tick();  // D_AR
    check("t2_d_arid",      32'(arid),      1);
    check("t2_d_araddr",    araddr,         32'h8000_0000);
    check("t2_d_arready",   32'(d_arready), 1);
    check("t2_i_arready",   32'(i_arready), 0);
    tick();  // D_R
    d_arvalid = 1'b0; d_rready = 1'b1; i_rready = 1'b1;
    for (int b = 0; b < 2; b++) begin
      rvalid = 1'b1; rdata = 32'hD000_0000 + 32'(b); rlast = (b == 1);
      #1;
      check("t2_d_rvalid",   32'(d_rvalid),  1);
      check("t2_d_rdata",    d_rdata,        32'hD000_0000 + 32'(b));
      check("t2_i_rvalid",   32'(i_rvalid),  0);
      check("t2_i_rdata",    i_rdata,        0);
      check("t2_burst_err",  32'(burst_err), 0);
      tick();
    end
    rvalid = 1'b0; rlast = 1'b0;
    #1;
    check("t2_idle_busy",    32'(busy),    0);
    check("t2_idle_arvalid", 32'(arvalid), 0);
    tick();  // I_AR
    check("t2_i_arid",    32'(arid),    0);
    check("t2_i_araddr",  araddr,       32'h0000_1000);
    check("t2_i_arvalid", 32'(arvalid), 1);
    tick();  // I_R
    i_arvalid = 1'b0;
    // i_rready toggles; each beat is held until accepted.
    for (int b = 0; b < 4; b++) begin
      rvalid = 1'b1; rdata = 32'hB000_0000 + 32'(b); rlast = (b == 3); i_rready = 1'b0;
      #1;
      check("t3_hold_rready",    32'(rready),    0);
      check("t3_hold_i_rvalid",  32'(i_rvalid),  1);
      check("t3_hold_d_rvalid",  32'(d_rvalid),  0);
      check("t3_hold_burst_err", 32'(burst_err), 0);
      tick();
      i_rready = 1'b1;
      #1;
      check("t3_acc_rready",    32'(rready),    1);
      check("t3_acc_i_rdata",   i_rdata,        32'hB000_0000 + 32'(b));
      check("t3_acc_burst_err", 32'(burst_err), 0);
      tick();
    end
    rvalid = 1'b0; rlast = 1'b0;
    #1;
    check("t3_end_busy", 32'(busy), 0);

    // ---------------- repeat tie: D again, with arready backpressure ----------------
    i_arvalid = 1'b1; d_arvalid = 1'b1; d_araddr = 32'h8000_0040; d_arlen = 4'd1;
    arready = 1'b0;
    tick();  // D_AR
    for (int k = 0; k < 5; k++) begin
      check("t3_bp_arid",      32'(arid),      1);
      check("t3_bp_arvalid",   32'(arvalid),   1);
      check("t3_bp_araddr",    araddr,         32'h8000_0040);
      check("t3_bp_d_arready", 32'(d_arready), 0);
      tick();
    end
    arready = 1'b1;
    #1;
    check("t3_bp_release", 32'(d_arready), 1);
    tick();  // D_R
    d_arvalid = 1'b0;
    for (int b = 0; b < 2; b++) begin
      rvalid = 1'b1; rdata = 32'hC000_0000 + 32'(b); rlast = (b == 1);
      #1;
      check("t3_d_rvalid", 32'(d_rvalid), 1);
      check("t3_i_rvalid", 32'(i_rvalid), 0);
      tick();
    end
    rvalid = 1'b0; rlast = 1'b0;
    tick();  // I_AR (I still requesting)
    check("t3_i_arid", 32'(arid), 0);
    i_arvalid = 1'b0;  // withdraw before the handshake
    #1;
    check("t4_withdraw_arvalid", 32'(arvalid), 0);
    tick();
    check("t4_withdraw_busy", 32'(busy), 0);
    // last_grant is I after the withdrawn grant, so D wins the next tie.
    i_arvalid = 1'b1; d_arvalid = 1'b1;
    tick();
    check("t4_tie_arid", 32'(arid), 1);
    i_arvalid = 1'b0; d_arvalid = 1'b0;
    tick();
    check("t4_idle_busy", 32'(busy), 0);

    // ---------------- length error: arlen=3, rlast on beat 2 ----------------
    d_arvalid = 1'b1; d_arlen = 4'd3; arready = 1'b1;
    tick();  // D_AR
    tick();  // D_R
    d_arvalid = 1'b0; d_rready = 1'b1;
    rvalid = 1'b1; rdata = 32'hE000_0000; rlast = 1'b0;
    #1;
    check("t5_beat1_err", 32'(burst_err), 0);
    tick();
    rdata = 32'hE000_0001; rlast = 1'b1;
    #1;
    check("t5_beat2_err",   32'(burst_err), 1);
    check("t5_beat2_rlast", 32'(d_rlast),   1);
    tick();
    rvalid = 1'b0; rlast = 1'b0;
    #1;
    check("t5_after_err",  32'(burst_err), 0);
    check("t5_after_busy", 32'(busy),      0);

    // ---------------- arlen=15: 16 beats, no error ----------------
    i_arvalid = 1'b1; i_arlen = 4'd15; i_araddr = 32'h0000_2000;
    tick();  // I_AR
    check("t6_arlen", 32'(arlen), 15);
    tick();  // I_R
    i_arvalid = 1'b0; i_rready = 1'b1;
    for (int b = 0; b < 16; b++) begin
      rvalid = 1'b1; rdata = 32'hF000_0000 + 32'(b); rlast = (b == 15);
      #1;
      check("t6_i_rvalid",   32'(i_rvalid),  1);
      check("t6_burst_err",  32'(burst_err), 0);
      check("t6_busy",       32'(busy),      1);
      tick();
    end
    rvalid = 1'b0; rlast = 1'b0;
    #1;
    check("t6_end_busy", 32'(busy), 0);

    // ---------------- reset during beat 4 of an 8-beat I burst ----------------
    i_arvalid = 1'b1; i_arlen = 4'd7;
    tick();  // I_AR
    tick();  // I_R
    i_arvalid = 1'b0;
    for (int b = 0; b < 3; b++) begin
      rvalid = 1'b1; rdata = 32'h5000_0000 + 32'(b); rlast = 1'b0;
      tick();
    end
    rdata = 32'h5000_0003; rst = 1'b1;
    tick();
    rst = 1'b0;
    rdata = 32'h5000_0004;  // memory keeps streaming
    #1;
    check("t7_busy",     32'(busy),     0);
    check("t7_rready",   32'(rready),   0);
    check("t7_i_rvalid", 32'(i_rvalid), 0);
    check("t7_arvalid",  32'(arvalid),  0);
    check("t7_arid",     32'(arid),     0);
    rvalid = 1'b0;
    d_arvalid = 1'b1; d_araddr = 32'h8000_0100;
    tick();  // D_AR
    check("t7_d_arid",    32'(arid),    1);
    check("t7_d_arvalid", 32'(arvalid), 1);
    check("t7_d_araddr",  araddr,       32'h8000_0100);
    d_arvalid = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/axi_rd_arbiter.md
AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter

Shares one burst read channel between the instruction cache and the data cache. One burst in flight at a time.

Interface
Parameters (name, default, meaning):
REQ-001 ID_WIDTH, 4, width of the arid port.
REQ-002 I_ID, 0, arid value driven for instruction-side bursts.
REQ-003 D_ID, 1, arid value driven for data-side bursts.

Ports (name, direction, width, meaning):
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 i_araddr/i_arlen/i_arsize/i_arvalid  in  32/4/3/1  instruction-side read request.
REQ-007 i_arready  out  1  instruction-side address accept.
REQ-008 i_rdata/i_rlast/i_rvalid  out  32/1/1  instruction-side read response.
REQ-009 i_rready  in  1  instruction-side response accept.
REQ-010 d_araddr/d_arlen/d_arsize/d_arvalid, d_arready, d_rdata/d_rlast/d_rvalid, d_rready  same widths/directions as the i_ signals  data-side copy.
REQ-011 araddr/arlen/arsize/arid/arvalid  out  32/4/3/ID_WIDTH/1  shared request to memory.
REQ-012 arready  in  1  memory address accept.
REQ-013 rdata/rlast/rvalid  in  32/1/1  memory read response.
REQ-014 rready  out  1  memory response accept.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 burst_err  out  1  one-cycle pulse on a beat-count mismatch.

Function
REQ-017 FSM states: IDLE, I_AR, I_R, D_AR, D_R. State and last_grant are registered.
REQ-018 IDLE transitions:
- only i_arvalid -> I_AR.
- only d_arvalid -> D_AR.
- both -> the side not in last_grant.
- neither -> stay in IDLE.
REQ-019 Entering X_AR sets last_grant = X.
REQ-020 Grant latency: a request seen in IDLE at cycle N drives arvalid=1 at cycle N+1. No combinational IDLE-to-arvalid path.
REQ-021 In X_AR, araddr/arlen/arsize are passed combinationally from the granted side, arvalid = x_arvalid, and x_arready = arready.
REQ-022 In X_AR, arvalid & arready moves to X_R next cycle and latches arlen into len_q.
REQ-023 In X_R, rdata/rlast/rvalid go to the granted side and rready = x_rready.
REQ-024 The ungranted side always sees arready=0 and rvalid=0; its rdata/rlast are don't-care, driven 0.
REQ-025 Beat counter (4 bits): cleared on entry to X_R; incremented on each rvalid & rready.
REQ-026 Burst end: rvalid & rready & rlast -> IDLE next cycle, with no idle bubble required beyond that cycle.
REQ-027 burst_err pulses for one cycle, at that same handshake, when beat count (including the last beat) != len_q+1. It is a pulse, not sticky.
REQ-028 A beat count passing len_q+1 without rlast does not terminate the burst; the burst ends only on rlast.
REQ-029 In IDLE: arvalid=0, rready=0. Responses arriving in IDLE are not accepted.
REQ-030 A requester deasserting arvalid while in X_AR before the handshake returns the FSM to IDLE next cycle; last_grant keeps its updated value.
REQ-031 arid = I_ID in I_AR/I_R and D_ID in D_AR/D_R; 0 in IDLE.
REQ-032 The counter wraps modulo 16. arlen=15 (16 beats) is legal and counts 0..15 without an error.

Reset
REQ-033 With rst high at an edge:
- state = IDLE, last_grant = I (so D wins the first tie), counter = 0, len_q = 0.
- All outputs are 0: arvalid, rready, i_arready, d_arready, i_rvalid, d_rvalid, burst_err, busy, arid.
REQ-034 Reset mid-burst abandons the burst immediately. The next cycle is IDLE with rready=0, and any later memory beats are not forwarded.

Verification
REQ-035 Single I request: i_araddr=0x1FC00000, arlen=7; arready at the first cycle of I_AR; 8 beats, rlast on the 8th -> arvalid one cycle after i_arvalid, arid=0, i_rvalid on all 8 beats, burst_err=0, busy drops the cycle after rlast.
REQ-036 Simultaneous i/d arvalid out of reset -> D granted first (arid=1). After D's rlast, I granted (arid=0). Repeat the simultaneous request -> D granted again (alternation).
REQ-037 Backpressure: arready held low for 5 cycles in D_AR, then i_rready toggled during I_R -> araddr stable while arvalid is high; beats counted only on rvalid & rready; no data delivered to the wrong side.
REQ-038 Length error: arlen=3, memory asserts rlast on beat 2 -> burst_err=1 for exactly one cycle, FSM returns to IDLE.
REQ-039 rst asserted during beat 4 of an 8-beat I burst -> next cycle: IDLE, rready=0, i_rvalid=0; a new d request afterwards is granted normally.
REQ-040 arlen=15 burst -> 16 beats accepted, burst_err=0.
